instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-003 SHALL have parameter BASE_ADDR, default 0, first word address written after reset.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  encode request present.
REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid&&in_ready.
REQ-008 SHALL have port op_class  input  3  0=R,1=LOAD,2=STORE,3=IMM,4=BRANCH,5=JAL,6=JALR,7=reserved.
REQ-009 SHALL have port alu_sel  input  4  team ALU code: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 BEQ,6 BNE,7 BLT,8 BGE,9 BLTU,10 BGEU.
REQ-010 SHALL have ports rd, rs1, rs2  input  5 each  register indices.
REQ-011 SHALL have port imm  input  32  byte offset/immediate, two's complement.
REQ-012 SHALL have port flush  input  1  one-cycle request to drain FIFO and signal completion.
REQ-013 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-014 SHALL have port imem_ready  input  1  memory accepts write when imem_we&&imem_ready.
REQ-015 SHALL have ports imem_addr  output  ADDR_W, imem_wdata  output  32  write address/encoded word.
REQ-016 SHALL have ports done  output  1  one-cycle drain-complete pulse; wr_count  output  ADDR_W+1  words written since reset; err  output  1  sticky illegal flag.

Function
REQ-017 SHALL encode opcodes R 0110011, LOAD 0000011, STORE 0100011, IMM 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111.
REQ-018 SHALL map alu_sel to funct3: ADD/SUB 000, AND 111, OR 110, XOR 100, BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111; LOAD/STORE funct3 010; JALR 000.
REQ-019 SHALL set funct7 0100000 only for R-type SUB, else 0000000.
REQ-020 SHALL place imm per format: I imm[11:0]; S imm[11:5]/imm[4:0]; B imm[12|10:5|4:1|11]; J imm[20|10:1|11|19:12]; bits above field and imm[0] for B/J ignored.
REQ-021 SHALL register the encoded word into the FIFO on the accepting edge; imem_we earliest asserts the following cycle (latency 1).
REQ-022 SHALL drive in_ready = !fifo_full && state!=DRAIN; no push while full, pop and push in same cycle allowed when not full.
REQ-023 SHALL hold imem_we/imem_addr/imem_wdata stable while imem_we&&!imem_ready.
REQ-024 SHALL on each accepted write pop FIFO, increment imem_addr modulo 2^ADDR_W (wraps to 0), increment wr_count (saturating at max).
REQ-025 SHALL implement FSM IDLE (FIFO empty) -> WRITE (FIFO non-empty) -> IDLE when last entry written; flush in any state -> DRAIN; DRAIN -> DONE when FIFO empty and no write pending; DONE -> IDLE after one cycle with done=1.
REQ-026 SHALL treat flush arriving with in_valid as: request not accepted that cycle.

Reset
REQ-027 SHALL on rst: FIFO emptied (in-flight entries discarded), state IDLE, in_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, wr_count=0, done=0, err=0.
REQ-028 SHALL give rst priority over flush, push and write in the same cycle.

Configuration
REQ-029 SHALL, with ENC_ILLEGAL_CHECK_EN defined, drop illegal requests (op_class 7; R alu_sel>4; IMM alu_sel in {1,>4}; BRANCH alu_sel<5 or >10; LOAD/STORE/JAL/JALR alu_sel!=0) without FIFO push and set err.
REQ-030 SHALL, without ENC_ILLEGAL_CHECK_EN, accept all requests, encode unmapped alu_sel as funct3 000/funct7 0, op_class 7 as opcode 0000000, err tied 0.

Structure
REQ-031 SHALL take opcode constants, op_class enum and alu_sel codes from shared package rv_enc_pkg, reused by the decode side.
REQ-032 SHALL instantiate one sub-module enc_fifo (DEPTH x 32, sync, full/empty).

Verification
REQ-033 SHALL test R SUB rd=3,rs1=1,rs2=2 -> imem_wdata 0x402081B3 at addr 0, one cycle after accept.
REQ-034 SHALL test BRANCH BNE rs1=1,rs2=2,imm=-4 -> 0xFE209EE3; JAL rd=1,imm=8 -> 0x008000EF.
REQ-035 SHALL test imem_ready=0 for 6 cycles with 5 requests -> in_ready low after 4 pushes, word/addr stable, all 5 written in order.
REQ-036 SHALL test ADDR_W=2, 5 writes -> addresses 0,1,2,3,0, wr_count=5.
REQ-037 SHALL test flush with 3 entries queued -> in_ready 0, 3 writes, done pulse exactly once, then IDLE.
REQ-038 SHALL test, with ENC_ILLEGAL_CHECK_EN, IMM alu_sel=1 -> no write, err=1 until rst.

Source files
------------

// File: rtl/rv_enc_pkg.sv
// Shared RV32 encode/decode definitions: opcodes, op classes, team ALU codes
// and the pure encode/legality functions used by the encoder.
package rv_enc_pkg;

    typedef enum logic [2:0] {
        OpR      = 3'd0,
        OpLoad   = 3'd1,
        OpStore  = 3'd2,
        OpImm    = 3'd3,
        OpBranch = 3'd4,
        OpJal    = 3'd5,
        OpJalr   = 3'd6,
        OpRsvd   = 3'd7
    } op_class_e;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluBeq  = 4'd5,
        AluBne  = 4'd6,
        AluBlt  = 4'd7,
        AluBge  = 4'd8,
        AluBltu = 4'd9,
        AluBgeu = 4'd10
    } alu_sel_e;

    localparam logic [6:0] OpcodeR      = 7'b0110011;
    localparam logic [6:0] OpcodeLoad   = 7'b0000011;
    localparam logic [6:0] OpcodeStore  = 7'b0100011;
    localparam logic [6:0] OpcodeImm    = 7'b0010011;
    localparam logic [6:0] OpcodeBranch = 7'b1100011;
    localparam logic [6:0] OpcodeJal    = 7'b1101111;
    localparam logic [6:0] OpcodeJalr   = 7'b1100111;
    localparam logic [6:0] Funct7Sub    = 7'b0100000;
    localparam logic [2:0] Funct3Word   = 3'b010;

    function automatic logic [2:0] alu_funct3(input logic [3:0] alu_sel);
        logic [2:0] f3;
        case (alu_sel)
            AluAnd:  f3 = 3'b111;
            AluOr:   f3 = 3'b110;
            AluXor:  f3 = 3'b100;
            AluBne:  f3 = 3'b001;
            AluBlt:  f3 = 3'b100;
            AluBge:  f3 = 3'b101;
            AluBltu: f3 = 3'b110;
            AluBgeu: f3 = 3'b111;
            default: f3 = 3'b000;
        endcase
        return f3;
    endfunction

    function automatic logic [31:0] encode(input logic [2:0]  op_class,
                                           input logic [3:0]  alu_sel,
                                           input logic [4:0]  rd,
                                           input logic [4:0]  rs1,
                                           input logic [4:0]  rs2,
                                           input logic [31:0] imm);
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] word;
        logic        unused_imm;
        // Upper immediate bits never reach any format.
        unused_imm = ^imm[31:21];
        f3   = alu_funct3(alu_sel);
        f7   = (alu_sel == AluSub) ? Funct7Sub : 7'b0000000;
        word = '0;
        case (op_class_e'(op_class))
            OpR:      word = {f7, rs2, rs1, f3, rd, OpcodeR};
            OpLoad:   word = {imm[11:0], rs1, Funct3Word, rd, OpcodeLoad};
            OpStore:  word = {imm[11:5], rs2, rs1, Funct3Word, imm[4:0], OpcodeStore};
            OpImm:    word = {imm[11:0], rs1, f3, rd, OpcodeImm};
            OpBranch: word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11],
                              OpcodeBranch};
            OpJal:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpcodeJal};
            OpJalr:   word = {imm[11:0], rs1, 3'b000, rd, OpcodeJalr};
            default:  word = '0;
        endcase
        return word;
    endfunction

    function automatic logic is_legal(input logic [2:0] op_class, input logic [3:0] alu_sel);
        logic ok;
        case (op_class_e'(op_class))
            OpR:      ok = (alu_sel <= AluXor);
            OpImm:    ok = (alu_sel <= AluXor) && (alu_sel != AluSub);
            OpBranch: ok = (alu_sel >= AluBeq) && (alu_sel <= AluBgeu);
            OpLoad, OpStore, OpJal, OpJalr: ok = (alu_sel == AluAdd);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous power-of-two FIFO holding encoded instruction words.
module enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FullCnt);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests into RV32 words and streams them into instruction memory.
// Define ENC_ILLEGAL_CHECK_EN to drop illegal requests and raise the sticky err flag.
module instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_class,
    input  logic [3:0]        alu_sel,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    input  logic              flush,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic              err
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {StIdle, StWrite, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic              fifo_full, fifo_empty;
    logic [CntW-1:0]   fifo_count;
    logic [31:0]       enc_word, fifo_head;
    logic              accept, push, pop, illegal;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   cnt_q;

    // A request arriving together with flush is refused.
    assign in_ready = !fifo_full && (state_q != StDrain);
    assign accept   = in_valid && in_ready && !flush;
    assign enc_word = encode(op_class, alu_sel, rd, rs1, rs2, imm);
    assign push     = accept && !illegal;
    assign imem_we  = !fifo_empty;
    assign pop      = imem_we && imem_ready;

    assign imem_wdata = fifo_empty ? 32'h0 : fifo_head;
    assign imem_addr  = addr_q;
    assign wr_count   = cnt_q;

`ifdef ENC_ILLEGAL_CHECK_EN
    logic err_q;

    assign illegal = !is_legal(op_class, alu_sel);
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && illegal) begin
            err_q <= 1'b1;
        end
    end
`else
    assign illegal = 1'b0;
    assign err     = 1'b0;
`endif

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (enc_word),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= ADDR_W'(BASE_ADDR);
            cnt_q  <= '0;
        end else if (pop) begin
            addr_q <= addr_q + 1'b1;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            StIdle:  if (!fifo_empty) state_d = StWrite;
            StWrite: if (pop && !push && fifo_count == CntW'(1)) state_d = StIdle;
            StDrain: if (fifo_empty) state_d = StDone;
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StDrain;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder: encoding table, back-pressure, address wrap,
// wr_count saturation, flush/drain and the illegal-request option.
module tb_instr_encoder;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    localparam int NumVec = 14;

    logic        clk, rst, in_valid, flush, imem_ready;
    logic [2:0]  op_class;
    logic [3:0]  alu_sel;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        in_ready, imem_we, done, err;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  wr_count;

    logic        unused_d2_ready, unused_d2_we, unused_d2_done, unused_d2_err;
    logic [31:0] unused_d2_wdata;
    logic [1:0]  d2_addr;
    logic [2:0]  d2_count;

    vec_t        vecs [NumVec];
    logic [7:0]  mon_addr [$];
    logic [31:0] mon_data [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          base     = 0;

    instr_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_class(op_class), .alu_sel(alu_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .flush(flush), .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .done(done), .wr_count(wr_count), .err(err)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(unused_d2_ready),
        .op_class(op_class), .alu_sel(alu_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .flush(flush), .imem_we(unused_d2_we), .imem_ready(imem_ready), .imem_addr(d2_addr),
        .imem_wdata(unused_d2_wdata), .done(unused_d2_done), .wr_count(d2_count),
        .err(unused_d2_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted write just before the edge that commits it.
    always begin
        @(negedge clk);
        #4;
        if (!rst && imem_we && imem_ready) begin
            mon_addr.push_back(imem_addr);
            mon_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input int k);
        in_valid = 1'b1;
        op_class = vecs[k].op;
        alu_sel  = vecs[k].alu;
        rd       = vecs[k].rd;
        rs1      = vecs[k].rs1;
        rs2      = vecs[k].rs2;
        imm      = vecs[k].imm;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        base = mon_data.size();
        check("rst_in_ready", in_ready, 1);
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_d2_addr", d2_addr, 0);
    endtask

    initial begin
        int done_cnt, writes_at_done, nw;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; imem_ready = 1'b1;
        op_class = '0; alu_sel = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;

        //          op    alu    rd     rs1    rs2    imm            expected word
        vecs[0]  = '{3'd0, 4'd1,  5'd3,  5'd1,  5'd2,  32'd0,         32'h402081B3};
        vecs[1]  = '{3'd0, 4'd0,  5'd3,  5'd1,  5'd2,  32'd0,         32'h002081B3};
        vecs[2]  = '{3'd0, 4'd2,  5'd5,  5'd6,  5'd7,  32'd0,         32'h007372B3};
        vecs[3]  = '{3'd1, 4'd0,  5'd10, 5'd2,  5'd0,  32'd16,        32'h01012503};
        vecs[4]  = '{3'd2, 4'd0,  5'd0,  5'd2,  5'd10, 32'hFFFFFFF8,  32'hFEA12C23};
        vecs[5]  = '{3'd3, 4'd0,  5'd1,  5'd0,  5'd0,  32'hFFFFFFFF,  32'hFFF00093};
        vecs[6]  = '{3'd3, 4'd4,  5'd2,  5'd2,  5'd0,  32'd5,         32'h00514113};
        vecs[7]  = '{3'd4, 4'd6,  5'd0,  5'd1,  5'd2,  32'hFFFFFFFC,  32'hFE209EE3};
        vecs[8]  = '{3'd4, 4'd5,  5'd0,  5'd0,  5'd0,  32'd8,         32'h00000463};
        vecs[9]  = '{3'd4, 4'd10, 5'd0,  5'd3,  5'd4,  32'h00000800,  32'h0041F0E3};
        vecs[10] = '{3'd5, 4'd0,  5'd1,  5'd0,  5'd0,  32'd8,         32'h008000EF};
        vecs[11] = '{3'd5, 4'd0,  5'd0,  5'd0,  5'd0,  32'hFFFFF800,  32'h801FF06F};
        vecs[12] = '{3'd6, 4'd0,  5'd0,  5'd1,  5'd0,  32'd0,         32'h00008067};
        vecs[13] = '{3'd3, 4'd0,  5'd1,  5'd0,  5'd0,  32'h00012345,  32'h34500093};

        // Encoding table, one request at a time; the ADDR_W=2 copy wraps and saturates.
        do_reset();
        for (int i = 0; i < NumVec; i++) begin
            drive(i);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("vec%0d_we", i), imem_we, 1);
            check($sformatf("vec%0d_word", i), imem_wdata, vecs[i].exp);
            check($sformatf("vec%0d_addr", i), imem_addr, i);
            check($sformatf("vec%0d_d2_addr", i), d2_addr, i % 4);
            check($sformatf("vec%0d_count", i), wr_count, i);
            check($sformatf("vec%0d_d2_count", i), d2_count, (i > 7) ? 7 : i);
            @(negedge clk);
        end
        check("table_count", wr_count, NumVec);
        check("table_d2_count_sat", d2_count, 7);
        check("table_idle_we", imem_we, 0);

        // Back-pressure: memory stalled, FIFO fills after four pushes.
        do_reset();
        imem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(k);
            check($sformatf("stall_ready%0d", k), in_ready, 1);
            @(negedge clk);
        end
        drive(4);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("stall_full%0d", s), in_ready, 0);
            check($sformatf("stall_we%0d", s), imem_we, 1);
            check($sformatf("stall_word%0d", s), imem_wdata, vecs[0].exp);
            check($sformatf("stall_addr%0d", s), imem_addr, 0);
            @(negedge clk);
        end
        imem_ready = 1'b1;
        @(negedge clk);
        check("stall_ready_after_pop", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 20 && (mon_data.size() - base) < 5; c++) @(negedge clk);
        nw = mon_data.size() - base;
        check("stall_writes", nw, 5);
        for (int k = 0; k < 5 && k < nw; k++) begin
            check($sformatf("stall_order_word%0d", k), mon_data[base + k], vecs[k].exp);
            check($sformatf("stall_order_addr%0d", k), mon_addr[base + k], k);
        end
        @(negedge clk);
        check("stall_count", wr_count, 5);

        // Flush with three queued; the request presented alongside flush is refused.
        do_reset();
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(k);
            @(negedge clk);
        end
        drive(3);
        flush = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("drain_in_ready", in_ready, 0);
        check("drain_no_done_yet", done, 0);
        imem_ready = 1'b1;
        done_cnt = 0;
        writes_at_done = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                writes_at_done = mon_data.size() - base;
            end
        end
        nw = mon_data.size() - base;
        check("drain_done_pulses", done_cnt, 1);
        check("drain_writes_at_done", writes_at_done, 3);
        check("drain_writes", nw, 3);
        for (int k = 0; k < 3 && k < nw; k++)
            check($sformatf("drain_word%0d", k), mon_data[base + k], vecs[k].exp);
        check("drain_idle_ready", in_ready, 1);
        check("drain_idle_we", imem_we, 0);

        // IMM with alu_sel=SUB.
        do_reset();
        in_valid = 1'b1; op_class = 3'd3; alu_sel = 4'd1;
        rd = 5'd5; rs1 = 5'd6; rs2 = 5'd0; imm = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        nw = mon_data.size() - base;
`ifdef ENC_ILLEGAL_CHECK_EN
        check("illegal_no_write", nw, 0);
        check("illegal_err", err, 1);
        repeat (3) @(negedge clk);
        check("illegal_err_sticky", err, 1);
        do_reset();
`else
        check("imm_sub_write", nw, 1);
        if (nw > 0) check("imm_sub_word", mon_data[base], 32'h00730293);
        check("imm_sub_err", err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
